// File: rtl/tx.sv
// tx -- serial transmitter for the single-bit tx_valid/tx_data link.
//
// Parallel bytes are queued in a small input FIFO. Each byte is sent
// LSB-first, one bit per clock, followed by GAP_CYCLES idle cycles. After
// FRAME_BYTES bytes the block waits for rx_finish (done) or gives up after
// FIN_TIMEOUT cycles (err), then starts the next frame.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_data    producer byte offer
//   in_ready            FIFO not full (combinational, low during reset)
//   rx_ready            receiver can take a new byte (sampled at byte start)
//   rx_finish           receiver completed the frame
//   tx_valid/tx_data    serial link, tx_data forced 0 when not valid
//   busy                frame in progress
//   byte_cnt            bytes completed in the current frame
//   done/err            one-cycle frame completion / timeout pulses
module tx #(
    parameter int DATA_W      = 8,
    parameter int FRAME_BYTES = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int FIN_TIMEOUT = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             in_ready,
    input  logic                             rx_ready,
    input  logic                             rx_finish,
    output logic                             tx_valid,
    output logic                             tx_data,
    output logic                             busy,
    output logic [$clog2(FRAME_BYTES+1)-1:0] byte_cnt,
    output logic                             done,
    output logic                             err
);
    localparam int CNT_W = $clog2(FRAME_BYTES + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int BIT_W = $clog2(DATA_W);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TMO_W = (FIN_TIMEOUT > 1) ? $clog2(FIN_TIMEOUT) : 1;

    localparam logic [AW:0]       DEPTH_C    = FIFO_DEPTH[AW:0];
    localparam logic [CNT_W-1:0]  FRAME_C    = CNT_W'(FRAME_BYTES);
    localparam logic [BIT_W-1:0]  LAST_BIT_C = BIT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0]  LAST_GAP_C = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TMO_W-1:0]  LAST_TMO_C = TMO_W'(FIN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_GAP      = 2'd2,
        ST_WAIT_FIN = 2'd3
    } state_t;

    // FIFO
    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       fifo_cnt_r;
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic [DATA_W-1:0] head_s;

    // FSM and datapath
    state_t            state_r, state_s;
    logic [DATA_W-1:0] shreg_r, shreg_s;
    logic [BIT_W-1:0]  bit_idx_r, bit_idx_s;
    logic [GAP_W-1:0]  gap_cnt_r, gap_cnt_s;
    logic [TMO_W-1:0]  tmo_cnt_r, tmo_cnt_s;
    logic [CNT_W-1:0]  byte_cnt_r, byte_cnt_s;
    logic              tx_valid_r, tx_valid_s;
    logic              tx_data_r, tx_data_s;
    logic              done_r, done_s;
    logic              err_r, err_s;
    logic              busy_r, busy_s;
    logic              start_s;
    logic              launch_ok_s;

    assign full_s   = (fifo_cnt_r == DEPTH_C);
    assign empty_s  = (fifo_cnt_r == {(AW + 1){1'b0}});
    assign in_ready = !full_s && !rst;
    assign push_s   = in_valid && in_ready;
    assign head_s   = mem_r[rd_ptr_r];

    // A new byte may start only from an idle link decision point.
    assign launch_ok_s = !empty_s && rx_ready && (byte_cnt_r < FRAME_C);

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            fifo_cnt_r <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= in_data;
                wr_ptr_r        <= wr_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + {{AW{1'b0}}, 1'b1};
                2'b01:   fifo_cnt_r <= fifo_cnt_r - {{AW{1'b0}}, 1'b1};
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Next-state and next-output logic; registered outputs reflect the next cycle
    always_comb begin
        state_s    = state_r;
        shreg_s    = shreg_r;
        bit_idx_s  = bit_idx_r;
        gap_cnt_s  = gap_cnt_r;
        tmo_cnt_s  = tmo_cnt_r;
        byte_cnt_s = byte_cnt_r;
        tx_valid_s = 1'b0;
        tx_data_s  = 1'b0;
        done_s     = 1'b0;
        err_s      = 1'b0;
        start_s    = 1'b0;
        pop_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (launch_ok_s) begin
                    start_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_idx_r == LAST_BIT_C) begin
                    byte_cnt_s = byte_cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
                    if (byte_cnt_s == FRAME_C) begin
                        state_s   = ST_WAIT_FIN;
                        tmo_cnt_s = {TMO_W{1'b0}};
                    end else if (GAP_CYCLES > 0) begin
                        state_s   = ST_GAP;
                        gap_cnt_s = {GAP_W{1'b0}};
                    end else if (!empty_s && rx_ready) begin
                        // No gap: chain straight into the next byte.
                        start_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    bit_idx_s  = bit_idx_r + {{(BIT_W - 1){1'b0}}, 1'b1};
                    tx_valid_s = 1'b1;
                    tx_data_s  = shreg_r[0];
                    shreg_s    = {1'b0, shreg_r[DATA_W-1:1]};
                end
            end
            ST_GAP: begin
                // The last gap edge doubles as the idle decision point so
                // the byte period is exactly DATA_W + GAP_CYCLES.
                if (gap_cnt_r == LAST_GAP_C) begin
                    if (launch_ok_s) begin
                        start_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    gap_cnt_s = gap_cnt_r + {{(GAP_W - 1){1'b0}}, 1'b1};
                end
            end
            ST_WAIT_FIN: begin
                if (rx_finish) begin
                    done_s     = 1'b1;
                    byte_cnt_s = {CNT_W{1'b0}};
                    state_s    = ST_IDLE;
                end else if (tmo_cnt_r == LAST_TMO_C) begin
                    err_s      = 1'b1;
                    byte_cnt_s = {CNT_W{1'b0}};
                    state_s    = ST_IDLE;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + {{(TMO_W - 1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Byte launch: pop the head and put bit 0 on the link next cycle.
        if (start_s) begin
            pop_s      = 1'b1;
            state_s    = ST_SHIFT;
            bit_idx_s  = {BIT_W{1'b0}};
            tx_valid_s = 1'b1;
            tx_data_s  = head_s[0];
            shreg_s    = {1'b0, head_s[DATA_W-1:1]};
        end else begin
            pop_s = 1'b0;
        end

        busy_s = (byte_cnt_s != {CNT_W{1'b0}}) || (state_s != ST_IDLE);
    end

    // FSM state, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            shreg_r    <= {DATA_W{1'b0}};
            bit_idx_r  <= {BIT_W{1'b0}};
            gap_cnt_r  <= {GAP_W{1'b0}};
            tmo_cnt_r  <= {TMO_W{1'b0}};
            byte_cnt_r <= {CNT_W{1'b0}};
            tx_valid_r <= 1'b0;
            tx_data_r  <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            shreg_r    <= shreg_s;
            bit_idx_r  <= bit_idx_s;
            gap_cnt_r  <= gap_cnt_s;
            tmo_cnt_r  <= tmo_cnt_s;
            byte_cnt_r <= byte_cnt_s;
            tx_valid_r <= tx_valid_s;
            tx_data_r  <= tx_data_s;
            done_r     <= done_s;
            err_r      <= err_s;
            busy_r     <= busy_s;
        end
    end

    assign tx_valid = tx_valid_r;
    assign tx_data  = tx_data_r;
    assign busy     = busy_r;
    assign byte_cnt = byte_cnt_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: doc/tx.md
# tx

Serial transmitter for the single-bit `tx_valid`/`tx_data` link consumed by `rx`. It accepts parallel bytes through a small input FIFO and serializes each byte LSB-first, one bit per clock, inserting a configurable idle gap between bytes. Once a full frame is sent, it waits for the receiver's `rx_finish`. The block sits on the transmit side of the link, between the byte producer and `rx`.

## Interface
- `DATA_W`, 8: bits per byte on the link; minimum 2.
- `FRAME_BYTES`, 4: bytes per frame before waiting on `rx_finish`; minimum 1.
- `FIFO_DEPTH`, 4: input FIFO entries; power of 2, minimum 2.
- `GAP_CYCLES`, 2: idle cycles (`tx_valid`=0) after each byte; 0 allowed.
- `FIN_TIMEOUT`, 64: cycles to wait for `rx_finish` before flagging an error; minimum 1.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer has a byte.
- `in_data`  in  DATA_W  byte to send.
- `in_ready`  out  1  FIFO can accept; a push happens on an edge where `in_valid & in_ready`.
- `rx_ready`  in  1  receiver can take a new byte.
- `rx_finish`  in  1  receiver has completed the frame.
- `tx_valid`  out  1  `tx_data` carries a valid bit this cycle.
- `tx_data`  out  1  serial bit, LSB first.
- `busy`  out  1  frame in progress (byte count ≠ 0 or state ≠ IDLE).
- `byte_cnt`  out  clog2(FRAME_BYTES+1)  bytes fully sent in the current frame.
- `done`  out  1  one-cycle pulse when the frame completes normally.
- `err`  out  1  one-cycle pulse on `rx_finish` timeout.

## Operation
- **FIFO**
  - `in_ready` = !full & !rst.
  - A push while full is impossible, because `in_ready` is low even if a pop occurs on the same edge.
  - Pop and push on the same edge are both performed when not full.
- **IDLE**
  - If the FIFO is non-empty, `rx_ready`=1, and `byte_cnt` < FRAME_BYTES: pop the head into the shift register, drive bit 0, and go to SHIFT.
  - Otherwise hold with `tx_valid`=0.
- **SHIFT**
  - Drive bits 0..DATA_W-1 on consecutive cycles with `tx_valid`=1.
  - `rx_ready` is ignored mid-byte; a started byte always completes.
  - After the last bit, increment `byte_cnt`.
  - If `byte_cnt` reaches FRAME_BYTES, go to WAIT_FIN.
  - Else if GAP_CYCLES > 0, go to GAP.
  - Else apply the IDLE conditions immediately. With GAP_CYCLES=0, back-to-back bytes produce no `tx_valid` low cycle.
- **GAP**
  - Hold `tx_valid`=0 for exactly GAP_CYCLES cycles, then go to IDLE.
- **WAIT_FIN**
  - `tx_valid`=0 and the timeout counter runs.
  - On `rx_finish`=1: pulse `done`, clear `byte_cnt`, go to IDLE.
  - After FIN_TIMEOUT cycles without `rx_finish`: pulse `err`, clear `byte_cnt`, go to IDLE.
  - `rx_finish` outside WAIT_FIN is ignored.
- FIFO contents are not affected by `err`.
- `tx_data` is 0 whenever `tx_valid`=0.

## Timing
- **Reset values:**
  - `tx_valid`=0, `tx_data`=0, `busy`=0, `byte_cnt`=0, `done`=0, `err`=0, `in_ready`=0.
  - FIFO empty; state IDLE.
  - `in_ready`=1 on the first cycle after `rst` falls.
- **Reset mid-operation:** the next edge with `rst`=1 forces all outputs and state to reset values. A partial byte is dropped, not resumed.
- **Latency:** a byte pushed on edge E into an empty FIFO, with state IDLE and `rx_ready`=1:
  - `tx_valid`=1 with bit 0 after edge E+1;
  - bit k after edge E+1+k;
  - `tx_valid`=0 after edge E+1+DATA_W when GAP_CYCLES > 0.
- **Per-byte period** with a continuous supply: DATA_W+GAP_CYCLES cycles.
- **rx_ready sampling:** only on the IDLE decision edge. `rx_ready` low holds the link idle indefinitely.
- **Frame counters:**
  - `byte_cnt` updates on the edge that ends the last bit.
  - `done`/`err` are high for exactly one cycle, on the cycle following the deciding edge.
  - `byte_cnt` reads 0 in that same cycle.
- **Outputs:** all outputs except `in_ready` are registered.

## Test plan
- **Nominal frame.** After reset, push 0xD5, 0x33, 0xAA, 0xF0 with `rx_ready`=1; `rx_finish` pulses 3 cycles after WAIT_FIN entry.
  - Required bits: 1,0,1,0,1,0,1,1 / 1,1,0,0,1,1,0,0 / 0,1,0,1,0,1,0,1 / 0,0,0,0,1,1,1,1.
  - Each byte is 8 `tx_valid` cycles, separated by 2 idle cycles.
  - `done` pulses once and `byte_cnt` returns to 0.
- **Backpressure.** Hold `rx_ready`=0 for 10 cycles after the first byte.
  - `tx_valid` stays 0 throughout.
  - The second byte starts 1 cycle after `rx_ready` rises.
  - Dropping `rx_ready` mid-byte does not truncate the byte.
- **FIFO full.** With `rx_ready`=0, push 5 bytes.
  - `in_ready` drops after 4 pushes and the 5th is not accepted.
  - Raising `rx_ready` drains the bytes in order.
- **GAP_CYCLES=0.** Send 4 bytes back-to-back.
  - `tx_valid` is high for 32 consecutive cycles.
- **Timeout.** `rx_finish` is never asserted.
  - `err` pulses exactly 64 cycles after WAIT_FIN entry; `done` never pulses.
  - The next frame proceeds normally.
- **Reset mid-byte.** Assert `rst` for 1 cycle after bit 3.
  - All outputs are 0 on the following cycle and the FIFO is empty.
  - A new push transmits from bit 0.
